// File: rtl/sti_dac_packer.sv
// sti_dac_packer: accepts one parallel word per load handshake, builds an
// 8/16/24/32-bit frame from it and shifts that frame out serially. The same
// bitstream is packed into PIX_W-bit pixels and written to pixel memory. At
// end of stream any partial pixel is flushed, the rest of memory is
// zero-filled and pixel_finish is raised.
module sti_dac_packer #(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  output logic              ready,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              so_data,
  output logic              so_valid,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_dataout,
  output logic              pixel_finish,
  output logic              pixel_ovf
);

  localparam int FW    = 2 * DATA_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam int PC_W  = $clog2(PIX_W + 1);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUILD = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_r, next_s;

  // Request fields captured on the accept cycle.
  logic [DATA_W-1:0] data_r;
  logic [1:0]        len_r;
  logic              fill_r, msb_r, low_r, end_r;

  // Serializer: frame shift register and count of bits still to emit.
  logic [FW-1:0] sr_r;
  logic [5:0]    bit_cnt_r;

  // Packer: bits collected so far and their number.
  logic [PIX_W-1:0] pix_sr_r;
  logic [PC_W-1:0]  pix_cnt_r;

  // Pixels written so far, saturating at DEPTH.
  logic [CW-1:0] wr_cnt_r;

  logic [5:0]        len_s;
  logic [FW-1:0]     frame_s;
  logic [FW-1:0]     aligned_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [CW-1:0]     next_cnt_s;
  logic              fill_go_s;

  // Frame formation: select/place the data word, then left-align for MSB-first.
  always_comb begin
    len_s   = {({1'b0, len_r} + 3'd1), 3'b000};
    frame_s = {FW{1'b0}};
    if (int'(len_s) <= DATA_W) begin
      if (low_r) begin
        frame_s = FW'(data_r) & ({FW{1'b1}} >> (FW - int'(len_s)));
      end else begin
        frame_s = FW'(data_r) >> (DATA_W - int'(len_s));
      end
    end else begin
      if (fill_r) begin
        frame_s = FW'(data_r) << (int'(len_s) - DATA_W);
      end else begin
        frame_s = FW'(data_r);
      end
    end
    if (msb_r) begin
      aligned_s = frame_s << (FW - int'(len_s));
    end else begin
      aligned_s = frame_s;
    end
  end

  // Address and count as they will be once the write in flight this cycle retires.
  always_comb begin
    next_addr_s = pixel_addr + ADDR_W'(pixel_wr);
    next_cnt_s  = wr_cnt_r + CW'(pixel_wr);
    fill_go_s   = (state_r == FILL) && (next_cnt_s < DEPTH_C);
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load && ready) next_s = BUILD;
        else               next_s = IDLE;
      end
      BUILD: next_s = SHIFT;
      SHIFT: begin
        if (bit_cnt_r == 6'd0) next_s = end_r ? DRAIN : IDLE;
        else                   next_s = SHIFT;
      end
      DRAIN: next_s = FILL;
      FILL: begin
        if (next_cnt_s >= DEPTH_C)      next_s = DONE;
        else if (next_addr_s == ADDR_MAX) next_s = DONE;
        else                            next_s = FILL;
      end
      DONE:    next_s = DONE;
      default: next_s = IDLE;
    endcase
  end

  // State register with registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ready   <= 1'b1;
    end else begin
      state_r <= next_s;
      ready   <= (next_s == IDLE);
    end
  end

  // Capture the request fields only when a load is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {DATA_W{1'b0}};
      len_r  <= 2'd0;
      fill_r <= 1'b0;
      msb_r  <= 1'b0;
      low_r  <= 1'b0;
      end_r  <= 1'b0;
    end else if (state_r == IDLE && load) begin
      data_r <= pi_data;
      len_r  <= pi_length;
      fill_r <= pi_fill;
      msb_r  <= pi_msb;
      low_r  <= pi_low;
      end_r  <= pi_end;
    end
  end

  // Serializer: BUILD presents the first bit, SHIFT presents the remaining ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_r      <= {FW{1'b0}};
      bit_cnt_r <= 6'd0;
      so_data   <= 1'b0;
      so_valid  <= 1'b0;
    end else begin
      case (state_r)
        BUILD: begin
          so_valid  <= 1'b1;
          so_data   <= msb_r ? aligned_s[FW-1] : aligned_s[0];
          sr_r      <= msb_r ? {aligned_s[FW-2:0], 1'b0} : {1'b0, aligned_s[FW-1:1]};
          bit_cnt_r <= len_s - 6'd1;
        end
        SHIFT: begin
          if (bit_cnt_r != 6'd0) begin
            so_valid  <= 1'b1;
            so_data   <= msb_r ? sr_r[FW-1] : sr_r[0];
            sr_r      <= msb_r ? {sr_r[FW-2:0], 1'b0} : {1'b0, sr_r[FW-1:1]};
            bit_cnt_r <= bit_cnt_r - 6'd1;
          end else begin
            so_valid <= 1'b0;
            so_data  <= 1'b0;
          end
        end
        default: begin
          so_valid <= 1'b0;
          so_data  <= 1'b0;
        end
      endcase
    end
  end

  // Packer and write issue: shift-packed pixels, the drain pixel, then zero fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_sr_r      <= {PIX_W{1'b0}};
      pix_cnt_r     <= {PC_W{1'b0}};
      pixel_wr      <= 1'b0;
      pixel_dataout <= {PIX_W{1'b0}};
    end else begin
      pixel_wr <= 1'b0;
      if (so_valid) begin
        if (pix_cnt_r == PC_W'(PIX_W - 1)) begin
          pixel_wr      <= 1'b1;
          pixel_dataout <= {pix_sr_r[PIX_W-2:0], so_data};
          pix_sr_r      <= {PIX_W{1'b0}};
          pix_cnt_r     <= {PC_W{1'b0}};
        end else begin
          pix_sr_r  <= {pix_sr_r[PIX_W-2:0], so_data};
          pix_cnt_r <= pix_cnt_r + PC_W'(1);
        end
      end else if (state_r == DRAIN) begin
        if (pix_cnt_r != {PC_W{1'b0}}) begin
          pixel_wr      <= 1'b1;
          pixel_dataout <= pix_sr_r << (PIX_W - int'(pix_cnt_r));
          pix_sr_r      <= {PIX_W{1'b0}};
          pix_cnt_r     <= {PC_W{1'b0}};
        end
      end else if (fill_go_s) begin
        pixel_wr      <= 1'b1;
        pixel_dataout <= {PIX_W{1'b0}};
      end
    end
  end

  // Address/count advance after each write; a write beyond DEPTH flags overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_addr <= {ADDR_W{1'b0}};
      wr_cnt_r   <= {CW{1'b0}};
      pixel_ovf  <= 1'b0;
    end else if (pixel_wr) begin
      pixel_addr <= pixel_addr + ADDR_W'(1);
      if (wr_cnt_r == DEPTH_C) pixel_ovf <= 1'b1;
      else                     wr_cnt_r  <= wr_cnt_r + CW'(1);
    end
  end

  // Finish flag, sticky once the machine has reached DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_finish <= 1'b0;
    end else if (state_r == DONE) begin
      pixel_finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sti_dac_packer.sv
// Bench for sti_dac_packer: two instances (PIX_W=8 and PIX_W=16) share the
// stimulus; a queue-based model predicts the serial bits and pixel writes.
module tb_sti_dac_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] pi_data = 16'h0;
  logic [1:0]  pi_length = 2'd0;
  logic        pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;

  logic        ready0, so_data0, so_valid0, pixel_wr0, pixel_finish0, pixel_ovf0;
  logic [7:0]  pixel_addr0;
  logic [7:0]  pixel_dataout0;
  logic        ready1, so_data1, so_valid1, pixel_wr1, pixel_finish1, pixel_ovf1;
  logic [7:0]  pixel_addr1;
  logic [15:0] pixel_dataout1;

  always #5 clk = ~clk;

  sti_dac_packer #(.DATA_W(16), .PIX_W(8), .ADDR_W(8)) dut0 (
    .clk(clk), .reset(reset), .load(load), .ready(ready0), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .so_data(so_data0), .so_valid(so_valid0), .pixel_wr(pixel_wr0),
    .pixel_addr(pixel_addr0), .pixel_dataout(pixel_dataout0),
    .pixel_finish(pixel_finish0), .pixel_ovf(pixel_ovf0));

  sti_dac_packer #(.DATA_W(16), .PIX_W(16), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .load(load), .ready(ready1), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .so_data(so_data1), .so_valid(so_valid1), .pixel_wr(pixel_wr1),
    .pixel_addr(pixel_addr1), .pixel_dataout(pixel_dataout1),
    .pixel_finish(pixel_finish1), .pixel_ovf(pixel_ovf1));

  int total = 0;
  int bad = 0;

  // model state
  bit so_q0[$];
  bit so_q1[$];
  int wq0[$];
  int wq1[$];
  bit pb0[$];
  bit pb1[$];
  int cnt0 = 0;
  int cnt1 = 0;
  int wr_k0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    so_q0.delete(); so_q1.delete(); wq0.delete(); wq1.delete();
    pb0.delete(); pb1.delete(); cnt0 = 0; cnt1 = 0;
  endtask

  task automatic emit0(input int v);
    wq0.push_back(((cnt0 % 256) << 16) | v);
    cnt0++;
  endtask

  task automatic emit1(input int v);
    wq1.push_back(((cnt1 % 256) << 16) | v);
    cnt1++;
  endtask

  task automatic model_bit(input bit b);
    int v;
    so_q0.push_back(b);
    so_q1.push_back(b);
    pb0.push_back(b);
    pb1.push_back(b);
    if (pb0.size() == 8) begin
      v = 0;
      foreach (pb0[j]) v = (v << 1) | int'(pb0[j]);
      emit0(v);
      pb0.delete();
    end
    if (pb1.size() == 16) begin
      v = 0;
      foreach (pb1[j]) v = (v << 1) | int'(pb1[j]);
      emit1(v);
      pb1.delete();
    end
  endtask

  // Frame of L bits built from the data word, emitted in the requested order.
  task automatic model_frame(input logic [15:0] d, input logic [1:0] len,
                             input logic fi, input logic ms, input logic lo);
    int L;
    logic [31:0] f;
    L = 8 * (int'(len) + 1);
    if (L <= 16) begin
      if (lo) f = {16'h0, d} & ((32'h1 << L) - 32'h1);
      else    f = {16'h0, d} >> (16 - L);
    end else begin
      if (fi) f = {d, 16'h0} >> (32 - L);
      else    f = {16'h0, d};
    end
    for (int i = 0; i < L; i++) model_bit(ms ? f[L-1-i] : f[i]);
  endtask

  // End of stream: partial pixel MSB-aligned, then zeros up to the last address.
  task automatic model_end();
    int v;
    if (pb0.size() > 0) begin
      v = 0;
      for (int j = 0; j < 8; j++) v = (v << 1) | ((j < pb0.size()) ? int'(pb0[j]) : 0);
      emit0(v);
      pb0.delete();
    end
    while (cnt0 < 256) emit0(0);
    if (pb1.size() > 0) begin
      v = 0;
      for (int j = 0; j < 16; j++) v = (v << 1) | ((j < pb1.size()) ? int'(pb1[j]) : 0);
      emit1(v);
      pb1.delete();
    end
    while (cnt1 < 256) emit1(0);
  endtask

  // Per-cycle compare of serial bits and pixel writes against the model.
  initial begin
    bit e;
    int w;
    forever begin
      @(posedge clk);
      #1;
      if (so_valid0 === 1'b1) begin
        chk("so_expected0", int'(so_q0.size() != 0), 1);
        if (so_q0.size() != 0) begin
          e = so_q0.pop_front();
          chk("so_data0", so_data0, e);
        end
      end
      if (so_valid1 === 1'b1) begin
        chk("so_expected1", int'(so_q1.size() != 0), 1);
        if (so_q1.size() != 0) begin
          e = so_q1.pop_front();
          chk("so_data1", so_data1, e);
        end
      end
      if (pixel_wr0 === 1'b1) begin
        chk("wr_expected0", int'(wq0.size() != 0), 1);
        if (wq0.size() != 0) begin
          w = wq0.pop_front();
          chk("wr_addr0", pixel_addr0, (w >> 16) & 32'hFF);
          chk("wr_data0", pixel_dataout0, w & 32'hFFFF);
        end
      end
      if (pixel_wr1 === 1'b1) begin
        chk("wr_expected1", int'(wq1.size() != 0), 1);
        if (wq1.size() != 0) begin
          w = wq1.pop_front();
          chk("wr_addr1", pixel_addr1, (w >> 16) & 32'hFF);
          chk("wr_data1", pixel_dataout1, w & 32'hFFFF);
        end
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready0"}, ready0, 1);
    chk({tag, "_ready1"}, ready1, 1);
    chk({tag, "_outs0"}, {so_data0, so_valid0, pixel_wr0, pixel_finish0, pixel_ovf0,
                          pixel_addr0, pixel_dataout0}, 0);
    chk({tag, "_outs1"}, {so_data1, so_valid1, pixel_wr1, pixel_finish1, pixel_ovf1,
                          pixel_addr1, pixel_dataout1}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_so_left"}, so_q0.size() + so_q1.size(), 0);
    chk({tag, "_wr_left0"}, wq0.size(), 0);
    chk({tag, "_wr_left1"}, wq1.size(), 0);
  endtask

  // One load handshake; waits for ready (or finish when en) with a bound.
  task automatic drive(input logic [15:0] d, input logic [1:0] len, input logic fi,
                       input logic ms, input logic lo, input logic en, input bit hold);
    int L, first_k, rk0, done_k;
    bit done;
    L = 8 * (int'(len) + 1);
    @(negedge clk);
    chk("ready_pre", {ready0, ready1}, 2'b11);
    pi_data = d; pi_length = len; pi_fill = fi; pi_msb = ms; pi_low = lo; pi_end = en;
    load = 1'b1;
    @(posedge clk);
    first_k = -1; rk0 = -1; wr_k0 = -1; done = 1'b0; done_k = -1;
    for (int k = 1; k <= 700 && !done; k++) begin
      @(negedge clk);
      if (!hold || k > L) load = 1'b0;
      if (so_valid0 && first_k < 0) first_k = k;
      if (pixel_wr0 && wr_k0 < 0) wr_k0 = k;
      if (ready0 && rk0 < 0) rk0 = k;
      if (en) done = pixel_finish0 && pixel_finish1;
      else    done = ready0 && ready1;
      if (done) done_k = k;
    end
    load = 1'b0;
    chk("wait_bound", int'(done), 1);
    chk("first_so_cycle", first_k, 2);
    if (!en) begin
      chk("ready_back0", rk0, L + 2);
      chk("ready_back_both", done_k, L + 2);
    end
  endtask

  task automatic after_done();
    pi_data = 16'h5A5A; pi_length = 2'd1; pi_end = 1'b0;
    load = 1'b1;
    repeat (20) @(negedge clk);
    load = 1'b0;
    chk("done_ready", {ready0, ready1}, 2'b00);
    chk("done_finish", {pixel_finish0, pixel_finish1}, 2'b11);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    // A: byte, high half, MSB-first
    do_reset();
    model_frame(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b0);
    v = 0;
    foreach (so_q0[i]) v = (v << 1) | int'(so_q0[i]);
    chk("pin_a_bits", v, 32'hA5);
    chk("pin_a_wr", wq0[0], 32'h0000_00A5);
    drive(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("a_wr_cycle", wr_k0, 10);
    check_drained("a");

    // B: 32-bit, fill=1, LSB-first
    do_reset();
    model_frame(16'h1234, 2'd3, 1'b1, 1'b0, 1'b0);
    chk("pin_b_n", wq0.size(), 4);
    chk("pin_b_w2", wq0[2], 32'h0002_002C);
    chk("pin_b_w3", wq0[3], 32'h0003_0048);
    drive(16'h1234, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_drained("b");

    // C: 24-bit, fill=0, MSB-first, end of stream
    do_reset();
    model_frame(16'hFFFF, 2'd2, 1'b0, 1'b1, 1'b0);
    model_end();
    chk("pin_c_w0", wq0[0], 32'h0000_0000);
    chk("pin_c_w2", wq0[2], 32'h0002_00FF);
    chk("pin_c_n", wq0.size(), 256);
    drive(16'hFFFF, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_drained("c");
    after_done();

    // D: single byte C3 with end (drain of a half pixel on the 16-bit instance)
    do_reset();
    model_frame(16'h00C3, 2'd0, 1'b0, 1'b1, 1'b1);
    model_end();
    chk("pin_d_w0", wq1[0], 32'h0000_C300);
    chk("pin_d_n", wq1.size(), 256);
    drive(16'h00C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_drained("d");
    after_done();

    // E: load held through SHIFT produces only one frame
    do_reset();
    model_frame(16'hBEEF, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(16'hBEEF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_drained("e");

    // F: reset mid-SHIFT
    do_reset();
    model_frame(16'hC0DE, 2'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    pi_data = 16'hC0DE; pi_length = 2'd1; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b0; pi_end = 1'b0;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("f_mid_shift", so_valid0, 1);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_idle_zero("f_abort");
    reset = 1'b0;

    // G: 257 byte frames -> wrap to address 0 and overflow
    do_reset();
    for (int i = 0; i < 257; i++) begin
      model_frame(16'(i), 2'd0, 1'b0, 1'b1, 1'b1);
      drive(16'(i), 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("pin_g_cnt0", cnt0, 257);
    chk("g_ovf0", pixel_ovf0, int'(cnt0 > 256));
    chk("g_ovf1", pixel_ovf1, int'(cnt1 > 256));
    chk("g_addr0", pixel_addr0, 8'd1);
    check_drained("g");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
